regfile_scoreboard: RTL
=======================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: ports clk and rst.
REQ-002 Parameter XLEN, 32, register data width in bits.
REQ-003 Parameter NREGS, 32, number of architectural registers (power of two, >=2); AW = log2(NREGS).
REQ-004 Parameter NRD, 2, number of independent read ports (1..4).
REQ-005 Parameter BYPASS, 1, 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 rs_addr  in  NRD*AW  packed read addresses; port k occupies bits [k*AW +: AW].
REQ-009 rs_data  out  NRD*XLEN  packed read data, combinational.
REQ-010 rs_busy  out  NRD  port k's register has an outstanding producer that is not resolved this cycle.
REQ-011 wr_en  in  1  writeback strobe.
REQ-012 rd_addr  in  AW  writeback destination.
REQ-013 wr_data  in  XLEN  writeback data.
REQ-014 iss_valid  in  1  an issuing instruction will write iss_rd.
REQ-015 iss_rd  in  AW  destination of the issuing instruction.
REQ-016 iss_ready  out  1  issue accepted this cycle.
REQ-017 flush  in  1  kill all outstanding producers.
REQ-018 pend_cnt  out  AW+1  number of pending registers, registered.
REQ-019 wb_err  out  1  sticky protocol error flag.

Function
REQ-020 Register 0 SHALL read 0 on every port, SHALL never be written, and SHALL never become pending.
REQ-021 On a rising edge with wr_en=1 and rd_addr!=0, the block SHALL store wr_data into reg[rd_addr].
REQ-022 rs_data port k SHALL return reg[rs_addr k] combinationally. With BYPASS=1, wr_en=1, rd_addr==rs_addr k and rd_addr!=0, port k SHALL return wr_data instead.
REQ-023 Each register SHALL have one pending bit.
REQ-024 rs_busy[k] SHALL be pending[rs_addr k] AND NOT (BYPASS=1 AND wr_en AND rd_addr==rs_addr k).
REQ-025 iss_ready SHALL be 1 when all of the following hold: flush=0; and either pending[iss_rd]=0, or the register is being written back this cycle (wr_en=1, rd_addr==iss_rd). This prevents a WAW hazard.
REQ-026 On a rising edge with iss_valid AND iss_ready AND iss_rd!=0, pending[iss_rd] SHALL be set.
REQ-027 On a rising edge with wr_en=1 and rd_addr!=0, pending[rd_addr] SHALL be cleared.
REQ-028 If a set and a clear hit the same register in the same cycle, the set SHALL win; the register ends pending with the new producer.
REQ-029 On a rising edge with flush=1, all pending bits SHALL be cleared. Flush overrides any same-cycle set; register writes still complete.
REQ-030 A writeback with rd_addr!=0 to a register whose pending bit is 0, with flush=0 in the previous cycle, SHALL set wb_err. wb_err SHALL hold until reset. The data write still occurs.
REQ-031 pend_cnt SHALL equal the popcount of the pending vector after each edge, with zero latency relative to the pending vector.
REQ-032 Latency: reads are 0 cycles (bypassed) or 1 cycle (write-then-read). The scoreboard update is visible to iss_ready and rs_busy on the cycle after the edge.

Reset
REQ-033 While rst=1 at a rising edge, the block SHALL clear all registers, all pending bits, pend_cnt and wb_err to 0.
REQ-034 Reset SHALL take priority over wr_en, iss_valid and flush.
REQ-035 Reset asserted mid-sequence SHALL discard all outstanding producers.
REQ-036 Outputs after reset SHALL be: rs_data=0, rs_busy=0, iss_ready=1 (when flush=0), pend_cnt=0, wb_err=0.

Structure
REQ-037 A shared package regfile_pkg SHALL hold the default XLEN/NREGS/NRD constants, the AW derivation and the port-slice helper.
REQ-038 The storage array with its read and bypass logic SHALL be a sub-module regfile_array. The scoreboard, counter and error flag SHALL reside in regfile_scoreboard.

Verification
REQ-039 Write-then-read: reset, then write x5=DEADBEEF and x10=CAFEBABE on consecutive cycles. Read ports 0/1 at 5/10 -> DEADBEEF and CAFEBABE.
REQ-040 Bypass: wr_en=1, rd_addr=7, wr_data=12345678, rs_addr0=7 in the same cycle -> rs_data0=12345678 combinationally. With BYPASS=0 -> old value 0.
REQ-041 x0: write FFFFFFFF to x0 and issue iss_rd=0 -> rs_data reads 0, pend_cnt stays 0, wb_err stays 0.
REQ-042 Scoreboard: issue x3, then x4 -> pend_cnt=2 and rs_busy set for port reading x3. A second issue to x3 -> iss_ready=0. Writeback x3 with a simultaneous issue to x3 -> iss_ready=1, x3 still pending, pend_cnt=2.
REQ-043 Flush: with x3 and x4 pending, assert flush together with iss_valid on x9 -> next cycle pend_cnt=0 and x9 not pending. A later writeback to x3 -> wb_err=1, which stays 1 until rst.
REQ-044 Reset mid-operation: with x6 pending and x6=AAAA5555, assert rst for one edge -> x6 reads 0, pend_cnt=0, wb_err=0, iss_ready=1.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file with issue scoreboard.
package regfile_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_NRD   = 2;

  // Address width for a register count; a single register still gets one address bit.
  function automatic int calc_aw(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  // Low bit of a port's slice inside a packed multi-port bus.
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_array.sv
// Register storage with NRD combinational read ports and optional write-to-read forwarding.
// Register 0 is hardwired to zero and is never written.
module regfile_array
  import regfile_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int NREGS  = DEF_NREGS,
  parameter int NRD    = DEF_NRD,
  parameter int BYPASS = 1,
  localparam int AW    = calc_aw(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  input  logic                wr_en,
  input  logic [AW-1:0]       rd_addr,
  input  logic [XLEN-1:0]     wr_data
);

  logic [XLEN-1:0] mem [NREGS];

  // Writeback into the array; reset zeroes every entry and x0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && (rd_addr != '0)) begin
      mem[rd_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_read
    logic [AW-1:0] addr;
    logic          fwd_hit;

    assign addr    = rs_addr[port_lsb(k, AW) +: AW];
    assign fwd_hit = (BYPASS != 0) && wr_en && (rd_addr == addr) && (addr != '0);
    assign rs_data[port_lsb(k, XLEN) +: XLEN] =
      (addr == '0) ? '0 : (fwd_hit ? wr_data : mem[addr]);
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file plus a per-register pending scoreboard that blocks WAW issue,
// reports read-port hazards, counts pending producers and flags stray writebacks.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int NREGS  = DEF_NREGS,
  parameter int NRD    = DEF_NRD,
  parameter int BYPASS = 1,
  localparam int AW    = calc_aw(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       rd_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic                iss_ready,
  input  logic                flush,
  output logic [AW:0]         pend_cnt,
  output logic                wb_err
);

  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pend_next;
  logic [AW:0]      cnt_next;
  logic             flush_q;
  logic             wb_hit;
  logic             iss_hit;

  regfile_array #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .NRD    (NRD),
    .BYPASS (BYPASS)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .rs_addr (rs_addr),
    .rs_data (rs_data),
    .wr_en   (wr_en),
    .rd_addr (rd_addr),
    .wr_data (wr_data)
  );

  assign wb_hit    = wr_en && (rd_addr != '0);
  assign iss_ready = !flush && (!pending[iss_rd] || (wr_en && (rd_addr == iss_rd)));
  assign iss_hit   = iss_valid && iss_ready && (iss_rd != '0);

  for (genvar k = 0; k < NRD; k++) begin : g_busy
    logic [AW-1:0] addr;

    assign addr       = rs_addr[port_lsb(k, AW) +: AW];
    assign rs_busy[k] = pending[addr] && !((BYPASS != 0) && wr_en && (rd_addr == addr));
  end

  // Next pending vector: writeback clears, a new producer overrides the clear, flush clears all.
  always_comb begin
    pend_next = pending;
    if (wb_hit) begin
      pend_next[rd_addr] = 1'b0;
    end
    if (iss_hit) begin
      pend_next[iss_rd] = 1'b1;
    end
    if (flush) begin
      pend_next = '0;
    end
    pend_next[0] = 1'b0;
    cnt_next = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt_next = cnt_next + {{AW{1'b0}}, pend_next[i]};
    end
  end

  // Scoreboard state, its population count, and the sticky stray-writeback flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      pend_cnt <= '0;
      flush_q  <= 1'b0;
      wb_err   <= 1'b0;
    end else begin
      pending  <= pend_next;
      pend_cnt <= cnt_next;
      flush_q  <= flush;
      if (wb_hit && !pending[rd_addr] && !flush_q) begin
        wb_err <= 1'b1;
      end
    end
  end

endmodule
